// File: rtl/secuenciador_mac_pkg.sv
// Shared constants and state encoding for the multiply-accumulate sequencer.
package secuenciador_mac_pkg;
  localparam int W          = 25;
  localparam int FRAC       = 10;
  localparam int NTERMS_DEF = 5;
  localparam int GUARD      = 4;
  localparam int AW         = W + GUARD;

  localparam logic [W-1:0] SAT_MAX = 25'h0FFFFFF;
  localparam logic [W-1:0] SAT_MIN = 25'h1000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEER = 2'd1,
    ACUM = 2'd2,
    FIN  = 2'd3
  } estado_t;
endpackage

// File: rtl/secuenciador_mac_if.sv
// Bus between the sequencer, its register file, the accumulator mux and the requester.
interface secuenciador_mac_if;
  import secuenciador_mac_pkg::*;

  // start is a one-cycle request honoured only in IDLE; done pulses for one cycle
  // when uk changes; coef_in/dato_in must carry the data for addr one cycle later.
  logic         start;
  logic [W-1:0] coef_in;
  logic [W-1:0] dato_in;
  logic [2:0]   addr;
  logic [W-1:0] term;
  logic [W-1:0] acum;
  logic         sel_ac;
  logic [W-1:0] uk;
  logic         busy;
  logic         done;
  estado_t      estado;

  modport master (
    output start, coef_in, dato_in,
    input  addr, term, acum, sel_ac, uk, busy, done, estado
  );

  modport slave (
    input  start, coef_in, dato_in,
    output addr, term, acum, sel_ac, uk, busy, done, estado
  );
endinterface

// File: rtl/secuenciador_mac_sat_escala.sv
// Signed multiply, arithmetic shift right by SH (floor), then clamp to W bits.
module sat_escala
  import secuenciador_mac_pkg::*;
#(
  parameter int IW = W,
  parameter int SH = FRAC
) (
  input  logic signed [IW-1:0] a,
  input  logic signed [IW-1:0] b,
  output logic        [W-1:0]  y
);
  localparam int PW = 2 * IW;
  localparam logic signed [PW-1:0] MAXV = {{(PW-W){1'b0}}, SAT_MAX};
  localparam logic signed [PW-1:0] MINV = {{(PW-W){1'b1}}, SAT_MIN};

  logic signed [PW-1:0] p;
  logic signed [PW-1:0] s;

  assign p = PW'(a) * PW'(b);
  assign s = p >>> SH;

  always_comb begin
    y = s[W-1:0];
    if (s > MAXV)      y = SAT_MAX;
    else if (s < MINV) y = SAT_MIN;
  end
endmodule

// File: rtl/secuenciador_mac.sv
// Sequencer computing u[k] = sum coef[i]*dato[i] over NTERMS terms with a guarded
// accumulator; drives the accumulator-select mux operands and a saturated result.
module secuenciador_mac
  import secuenciador_mac_pkg::*;
#(
  parameter int NTERMS = NTERMS_DEF
) (
  input logic               clk,
  input logic               rst,
  secuenciador_mac_if.slave bus
);
  localparam logic [2:0] LAST  = 3'(NTERMS - 1);
  localparam logic [2:0] ADDR1 = (NTERMS > 1) ? 3'd1 : 3'd0;
  localparam logic signed [AW-1:0] UNO = AW'(1);

  estado_t estado_q, estado_d;
  logic [2:0]           addr_q, cnt_q;
  logic signed [AW-1:0] acc_q, acc_d, term_ext;
  logic [W-1:0]         term_w, acum_w, term_q, acum_q, uk_q;
  logic                 sel_q, busy_q, done_q;

  sat_escala #(.IW(W), .SH(FRAC)) u_term (
    .a(bus.coef_in), .b(bus.dato_in), .y(term_w)
  );

  // Saturated terms are widened before adding so the guard bits absorb growth;
  // only the registered view of the accumulator is clamped.
  assign term_ext = {{GUARD{term_w[W-1]}}, term_w};
  assign acc_d    = (cnt_q == 3'd0) ? term_ext : acc_q + term_ext;

  sat_escala #(.IW(AW), .SH(0)) u_acum (
    .a(acc_d), .b(UNO), .y(acum_w)
  );

  always_ff @(posedge clk) begin
    if (rst) estado_q <= IDLE;
    else     estado_q <= estado_d;
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      IDLE:    if (bus.start) estado_d = LEER;
      LEER:    estado_d = ACUM;
      ACUM:    if (cnt_q == LAST) estado_d = FIN;
      FIN:     estado_d = IDLE;
      default: estado_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      cnt_q  <= '0;
      acc_q  <= '0;
      term_q <= '0;
      acum_q <= '0;
      uk_q   <= '0;
      sel_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (estado_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            addr_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
          end
        end
        LEER: addr_q <= ADDR1;
        ACUM: begin
          acc_q  <= acc_d;
          term_q <= term_w;
          acum_q <= acum_w;
          sel_q  <= (cnt_q != 3'd0);
          cnt_q  <= cnt_q + 3'd1;
          if (addr_q < LAST) addr_q <= addr_q + 3'd1;
        end
        FIN: begin
          // acum_q already holds sat_W(acc) for the final sum.
          uk_q   <= acum_q;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          addr_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.addr   = addr_q;
  assign bus.term   = term_q;
  assign bus.acum   = acum_q;
  assign bus.sel_ac = sel_q;
  assign bus.uk     = uk_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.estado = estado_q;
endmodule
